// File: rtl/rv32i_types.sv
// Shared types for the pipeline hazard controller: FSM state and scoreboard slot.
package rv32i_types;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_slot_t;

  localparam sb_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master = pipeline, slave = controller.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  import rv32i_types::*;

  logic [4:0]       id_rs1_usage_i;
  logic [4:0]       id_rs2_usage_i;
  logic [4:0]       id_rd_usage_i;
  logic             id_is_load_i;
  logic             id_valid_i;
  logic             br_taken_i;
  logic             imem_busy_i;
  logic             dmem_busy_i;
  logic             freeze_o;
  logic             stall_front_o;
  logic             bubble_ex_o;
  logic             flush_front_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  // Debug/RVFI visibility of the controller state and scoreboard.
  hazard_state_t    state;
  sb_slot_t         ex_slot;
  sb_slot_t         mem_slot;

  modport master (
    output id_rs1_usage_i, id_rs2_usage_i, id_rd_usage_i, id_is_load_i, id_valid_i,
           br_taken_i, imem_busy_i, dmem_busy_i,
    input  freeze_o, stall_front_o, bubble_ex_o, flush_front_o,
           stall_cnt_o, flush_cnt_o, state, ex_slot, mem_slot
  );

  modport slave (
    input  id_rs1_usage_i, id_rs2_usage_i, id_rd_usage_i, id_is_load_i, id_valid_i,
           br_taken_i, imem_busy_i, dmem_busy_i,
    output freeze_o, stall_front_o, bubble_ex_o, flush_front_o,
           stall_cnt_o, flush_cnt_o, state, ex_slot, mem_slot
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating stall/flush event counters for the hazard controller.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_ev,
  input  logic             flush_ev,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use stall.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input logic         clk_i,
  input logic         rst_i,
  hazard_ctrl_if.slave bus
);

  hazard_state_t state;
  sb_slot_t      ex_slot;
  sb_slot_t      mem_slot;
  logic          load_use;
  logic          freeze;
  logic          stall_front;
  logic          bubble_ex;
  logic          flush_front;

  // Only the EX slot can stall: a load already in MEM is covered by forwarding.
  assign load_use = bus.id_valid_i && ex_slot.valid && ex_slot.is_load &&
                    (ex_slot.rd != 5'd0) &&
                    ((bus.id_rs1_usage_i == ex_slot.rd) ||
                     (bus.id_rs2_usage_i == ex_slot.rd));

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    freeze      = 1'b0;
    stall_front = 1'b0;
    bubble_ex   = 1'b0;
    flush_front = 1'b0;
    if (rst_i) begin
      freeze = 1'b0;
    end else if (bus.dmem_busy_i) begin
      freeze = 1'b1;
    end else if (bus.br_taken_i) begin
      flush_front = 1'b1;
      bubble_ex   = 1'b1;
    end else if (load_use || bus.imem_busy_i) begin
      stall_front = 1'b1;
      bubble_ex   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      ex_slot  <= SLOT_EMPTY;
      mem_slot <= SLOT_EMPTY;
    end else begin
      case (state)
        RUN:     if (bus.dmem_busy_i) state <= DWAIT;
                 else if (bus.imem_busy_i) state <= IWAIT;
        DWAIT:   if (!bus.dmem_busy_i) state <= RUN;
        IWAIT:   if (bus.dmem_busy_i) state <= DWAIT;
                 else if (!bus.imem_busy_i) state <= RUN;
        default: state <= RUN;
      endcase
      if (!freeze) begin
        // NOTE: non-blocking, so MEM captures the pre-edge EX contents.
        mem_slot <= ex_slot;
        ex_slot  <= bubble_ex ? SLOT_EMPTY
                              : '{valid: bus.id_valid_i, rd: bus.id_rd_usage_i,
                                  is_load: bus.id_is_load_i};
      end
    end
  end

  assign bus.freeze_o      = freeze;
  assign bus.stall_front_o = stall_front;
  assign bus.bubble_ex_o   = bubble_ex;
  assign bus.flush_front_o = flush_front;
  assign bus.state         = state;
  assign bus.ex_slot       = ex_slot;
  assign bus.mem_slot      = mem_slot;

`ifdef HAZARD_STATS_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .stall_ev  (freeze | stall_front),
    .flush_ev  (flush_front),
    .stall_cnt (bus.stall_cnt_o),
    .flush_cnt (bus.flush_cnt_o)
  );
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
  assign bus.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic vs a reference model.
module tb_hazard_ctrl;
  import rv32i_types::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();
  hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk_i(clk), .rst_i(rst), .bus(hif));

  typedef struct {
    bit valid;
    int rd;
    bit ld;
  } instr_t;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: in-flight instructions (index 0 = EX, 1 = MEM), wait state, event counts.
  instr_t        pipe[$];
  hazard_state_t m_state;
  int            m_stalls, m_flushes;

  // Current stimulus, kept by the bench itself.
  bit cur_v, cur_ld, cur_br, cur_ib, cur_db;
  int cur_rs1, cur_rs2, cur_rd;

  // Last observed outputs, for scenario-specific checks.
  logic obs_frz, obs_stall, obs_bub, obs_fl;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, int rs1, int rs2, int rd, bit ld, bit br, bit ib, bit db);
    cur_v = v; cur_rs1 = rs1; cur_rs2 = rs2; cur_rd = rd; cur_ld = ld;
    cur_br = br; cur_ib = ib; cur_db = db;
    hif.id_valid_i     = v;
    hif.id_rs1_usage_i = 5'(rs1);
    hif.id_rs2_usage_i = 5'(rs2);
    hif.id_rd_usage_i  = 5'(rd);
    hif.id_is_load_i   = ld;
    hif.br_taken_i     = br;
    hif.imem_busy_i    = ib;
    hif.dmem_busy_i    = db;
  endtask

  function automatic int sat(int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  function automatic void model_reset();
    instr_t empty = '{valid: 1'b0, rd: 0, ld: 1'b0};
    pipe.delete();
    pipe.push_back(empty);
    pipe.push_back(empty);
    m_state   = RUN;
    m_stalls  = 0;
    m_flushes = 0;
  endfunction

  function automatic void model_advance(bit frz, bit bub, bit stall, bit fl);
    instr_t nxt;
    if (!frz) begin
      nxt = bub ? '{valid: 1'b0, rd: 0, ld: 1'b0} : '{valid: cur_v, rd: cur_rd, ld: cur_ld};
      pipe.push_front(nxt);
      void'(pipe.pop_back());
    end
    if (cur_db)                m_state = DWAIT;
    else if (m_state == DWAIT) m_state = RUN;
    else                       m_state = cur_ib ? IWAIT : RUN;
    if (frz || stall) m_stalls++;
    if (fl)           m_flushes++;
  endfunction

  task automatic check_counters(string tag);
`ifdef HAZARD_STATS_EN
    check({tag, ".stall_cnt"}, 32'(hif.stall_cnt_o), 32'(sat(m_stalls)));
    check({tag, ".flush_cnt"}, 32'(hif.flush_cnt_o), 32'(sat(m_flushes)));
`else
    check({tag, ".stall_cnt"}, 32'(hif.stall_cnt_o), 32'd0);
    check({tag, ".flush_cnt"}, 32'(hif.flush_cnt_o), 32'd0);
`endif
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance both at the edge.
  task automatic cycle(string tag);
    bit hz, e_frz, e_fl, e_stall, e_bub;
    @(negedge clk);
    hz = cur_v && pipe[0].valid && pipe[0].ld && pipe[0].rd != 0 &&
         (cur_rs1 == pipe[0].rd || cur_rs2 == pipe[0].rd);
    e_frz   = cur_db;
    e_fl    = !cur_db && cur_br;
    e_stall = !cur_db && !cur_br && (hz || cur_ib);
    e_bub   = e_fl || e_stall;
    obs_frz = hif.freeze_o; obs_stall = hif.stall_front_o;
    obs_bub = hif.bubble_ex_o; obs_fl = hif.flush_front_o;
    check({tag, ".freeze"}, 32'(obs_frz),   32'(e_frz));
    check({tag, ".stall"},  32'(obs_stall), 32'(e_stall));
    check({tag, ".bubble"}, 32'(obs_bub),   32'(e_bub));
    check({tag, ".flush"},  32'(obs_fl),    32'(e_fl));
    check({tag, ".state"},  32'(hif.state), 32'(m_state));
    check({tag, ".ex_v"},   32'(hif.ex_slot.valid),  32'(pipe[0].valid));
    check({tag, ".mem_v"},  32'(hif.mem_slot.valid), 32'(pipe[1].valid));
    if (pipe[0].valid) begin
      check({tag, ".ex_rd"}, 32'(hif.ex_slot.rd),      32'(pipe[0].rd));
      check({tag, ".ex_ld"}, 32'(hif.ex_slot.is_load), 32'(pipe[0].ld));
    end
    check_counters(tag);
    @(posedge clk);
    model_advance(e_frz, e_bub, e_stall, e_fl);
    #1;
  endtask

  // Assert reset (possibly mid-cycle), check the immediate effect, release on a negedge.
  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    check({tag, ".freeze"}, 32'(hif.freeze_o),      32'd0);
    check({tag, ".stall"},  32'(hif.stall_front_o), 32'd0);
    check({tag, ".bubble"}, 32'(hif.bubble_ex_o),   32'd0);
    check({tag, ".flush"},  32'(hif.flush_front_o), 32'd0);
    check({tag, ".state"},  32'(hif.state),         32'(RUN));
    check({tag, ".ex_v"},   32'(hif.ex_slot.valid),  32'd0);
    check({tag, ".mem_v"},  32'(hif.mem_slot.valid), 32'd0);
    model_reset();
    check_counters(tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    model_advance(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    drive(1, 5, 5, 5, 1, 1, 1, 1);
    do_reset("por");

    // lw x5 followed by add x6,x5,x1: one stall cycle, then the add proceeds.
    drive(1, 1, 0, 5, 1, 0, 0, 0); cycle("lw_x5");
    drive(1, 5, 1, 6, 0, 0, 0, 0); cycle("add_stall");
    check("lu.stall_on",  32'(obs_stall), 32'd1);
    check("lu.bubble_on", 32'(obs_bub),   32'd1);
    cycle("add_go");
    check("lu.stall_off",  32'(obs_stall), 32'd0);
    check("lu.bubble_off", 32'(obs_bub),   32'd0);

    // Load to x0 never creates a hazard.
    drive(1, 0, 0, 0, 1, 0, 0, 0); cycle("lw_x0");
    drive(1, 0, 0, 3, 0, 0, 0, 0); cycle("use_x0");
    check("x0.no_stall", 32'(obs_stall), 32'd0);

    // Taken branch masks a simultaneous load-use stall.
    drive(1, 2, 0, 7, 1, 0, 0, 0); cycle("lw_x7");
    drive(1, 7, 0, 8, 0, 1, 0, 0); cycle("br_vs_lu");
    check("brlu.flush",  32'(obs_fl),    32'd1);
    check("brlu.bubble", 32'(obs_bub),   32'd1);
    check("brlu.stall",  32'(obs_stall), 32'd0);

    // Data-memory wait with a pending branch: three frozen cycles, then the flush.
    drive(1, 1, 2, 9, 0, 0, 0, 0); cycle("pre_dwait");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2, 10, 0, 1, 0, 1); cycle("dwait_br");
      check("dw.freeze", 32'(obs_frz), 32'd1);
      check("dw.flush",  32'(obs_fl),  32'd0);
    end
    drive(1, 1, 2, 10, 0, 1, 0, 0); cycle("dwait_done");
    check("dw.freeze_off", 32'(obs_frz), 32'd0);
    check("dw.flush_late", 32'(obs_fl),  32'd1);

    // Reset asserted while waiting on data memory.
    drive(1, 3, 0, 4, 1, 0, 0, 0); cycle("pre_rst");
    drive(1, 4, 0, 5, 0, 1, 1, 1); cycle("enter_dwait");
    check("rdw.state", 32'(hif.state), 32'(DWAIT));
    do_reset("rst_mid_dwait");
    check("rdw.post_state", 32'(hif.state),         32'(RUN));
    check("rdw.post_ex",    32'(hif.ex_slot.valid),  32'd0);
    check("rdw.post_mem",   32'(hif.mem_slot.valid), 32'd0);

    // Twenty instruction-memory wait cycles saturate a 4-bit stall counter.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, 1, 0, 0, 1, 0); cycle("imem_wait");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); cycle("idle");
`ifdef HAZARD_STATS_EN
    check("sat.stall_cnt", 32'(hif.stall_cnt_o), 32'd15);
`else
    check("sat.stall_cnt", 32'(hif.stall_cnt_o), 32'd0);
`endif

    // Random traffic over a small register set to provoke overlaps.
    do_reset("pre_rand");
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 6) == 0));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of statistics counters.
REQ-002 SHALL have port clk_i  in  1  single pipeline clock.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports id_rs1_usage_i / id_rs2_usage_i / id_rd_usage_i  in  5 each  ID-stage register usage; 0 = unused.
REQ-005 SHALL have port id_is_load_i  in  1  ID instruction is a load.
REQ-006 SHALL have port id_valid_i  in  1  ID holds a real instruction.
REQ-007 SHALL have port br_taken_i  in  1  EX resolved taken branch/jump.
REQ-008 SHALL have ports imem_busy_i / dmem_busy_i  in  1 each  memory request outstanding, no response this cycle.
REQ-009 SHALL have ports freeze_o / stall_front_o / bubble_ex_o / flush_front_o  out  1 each  hold all pipe regs / hold PC+IF/ID / load NOP into ID/EX / load NOP into IF/ID.
REQ-010 SHALL have ports stall_cnt_o / flush_cnt_o  out  CNT_W each  statistics (zero when feature absent).

Function
REQ-011 SHALL keep a two-slot scoreboard (EX, MEM), each {valid, rd[4:0], is_load}.
REQ-012 SHALL, on a clock edge with freeze_o=0, shift EX slot into MEM and load EX slot from {id_valid_i, id_rd_usage_i, id_is_load_i}, or invalid when bubble_ex_o=1.
REQ-013 SHALL hold both slots unchanged while freeze_o=1.
REQ-014 SHALL implement FSM states RUN, DWAIT, IWAIT; RUN->DWAIT on dmem_busy_i; RUN->IWAIT on imem_busy_i and !dmem_busy_i; DWAIT->RUN when !dmem_busy_i; IWAIT->RUN when !imem_busy_i; IWAIT->DWAIT on dmem_busy_i.
REQ-015 SHALL assert freeze_o combinationally whenever dmem_busy_i=1, in any state; all other outputs 0 that cycle.
REQ-016 SHALL define load-use hazard = id_valid_i & EX.valid & EX.is_load & EX.rd!=0 & (id_rs1_usage_i==EX.rd | id_rs2_usage_i==EX.rd).
REQ-017 SHALL, on load-use hazard without freeze or flush, assert stall_front_o=1 and bubble_ex_o=1 for exactly one cycle (the load moves to MEM, hazard clears).
REQ-018 SHALL, on br_taken_i=1 without freeze, assert flush_front_o=1 and bubble_ex_o=1 for one cycle, stall_front_o=0.
REQ-019 SHALL give priority freeze > flush > load-use > imem wait; flush masks a simultaneous load-use stall.
REQ-020 SHALL ignore br_taken_i while frozen; the branch is acted on in the first unfrozen cycle (EX held).
REQ-021 SHALL, on imem_busy_i alone, assert stall_front_o=1 and bubble_ex_o=1 (front starves, back drains).
REQ-022 SHALL never flag hazards on register x0; MEM slot informs RVFI/debug only, not stalls (forwarding covers it).

Reset
REQ-023 SHALL, on rst_i=1, asynchronously force state RUN, both slots invalid, counters 0.
REQ-024 SHALL drive all control outputs 0 while rst_i=1, independent of inputs.
REQ-025 SHALL resume from RUN with empty scoreboard if reset is asserted mid-DWAIT/IWAIT.

Configuration
REQ-026 SHALL, with HAZARD_STATS_EN defined, increment stall_cnt_o each cycle any of freeze_o/stall_front_o is 1, and flush_cnt_o each cycle flush_front_o=1, both saturating at all-ones.
REQ-027 SHALL, without HAZARD_STATS_EN, tie stall_cnt_o and flush_cnt_o to 0 and instantiate no counter logic.

Structure
REQ-028 SHALL place hazard_state_t enum (RUN, DWAIT, IWAIT) and scoreboard-slot struct in package rv32i_types.
REQ-029 SHALL implement counters in sub-module hazard_perf_cnt, instantiated only under HAZARD_STATS_EN.

Verification
REQ-030 SHALL cover: ID lw x5 -> next ID add x6,x5,x1 -> stall_front_o=1, bubble_ex_o=1 exactly 1 cycle, then 0.
REQ-031 SHALL cover: EX load rd=0, ID uses rs1=0 -> no stall.
REQ-032 SHALL cover: br_taken_i=1 same cycle as load-use hazard -> flush_front_o=1, bubble_ex_o=1, stall_front_o=0.
REQ-033 SHALL cover: dmem_busy_i=1 for 3 cycles with br_taken_i=1 -> freeze_o=1 three cycles, flush_front_o=1 on cycle 4.
REQ-034 SHALL cover: rst_i asserted mid-DWAIT -> outputs 0 immediately, state RUN, scoreboard empty after release.
REQ-035 SHALL cover (HAZARD_STATS_EN, CNT_W=4): 20 stall cycles -> stall_cnt_o=15 saturated.
